// File: rtl/temp_sample_conditioner_pkg.sv
// temp_sample_conditioner_pkg
//   Shared definitions for the temperature sample conditioner:
//   - FSM state encodings
//   - Fahrenheit offset
//   - divider width and constant divisor
//   - the 9c+2 helper used to build the Fahrenheit dividend
package temp_sample_conditioner_pkg;

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_ROUND  = 2'd1;
  localparam logic [1:0] ST_DIV    = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  localparam int SAMPLE_W  = 12;
  localparam int OUT_W     = 8;
  localparam int F_OFFSET  = 32;
  localparam int DIV_BITS  = 11;
  localparam int DIV_CONST = 5;

  // 9*c + 2 built from a shift and adds; the +2 turns the floor of the
  // later divide-by-5 into round-to-nearest for 1.8*c.
  function automatic logic [DIV_BITS-1:0] times9_plus2(input logic [OUT_W-1:0] c);
    logic [DIV_BITS-1:0] cx;
    cx = {{(DIV_BITS-OUT_W){1'b0}}, c};
    return (cx << 3) + cx + DIV_BITS'(2);
  endfunction

endpackage

// File: rtl/temp_sample_conditioner_if.sv
// temp_sample_conditioner_if
//   Raw sample valid/ready handshake from the sensor interface.
//   sample_valid : sample present (source -> conditioner)
//   sample_data  : signed sample, 1/16 degC LSB (source -> conditioner)
//   sample_ready : conditioner can take a sample (conditioner -> source)
interface temp_sample_conditioner_if;
  import temp_sample_conditioner_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_ready;

  modport master (output sample_valid, output sample_data, input sample_ready);
  modport slave  (input sample_valid, input sample_data, output sample_ready);

endinterface

// File: rtl/temp_sample_conditioner_seq_div_const.sv
// seq_div_const
//   Restoring divider by a constant, one quotient bit per cycle, MSB first.
//   Ports:
//     clk, rst         : clock, async active-low reset
//     start            : load dividend (ignored state is discarded)
//     dividend         : WIDTH-bit unsigned dividend
//     done             : high in the cycle whose clock edge computes the final
//                        quotient bit; quotient/remainder are valid after it
//     quotient         : WIDTH-bit quotient
//     remainder        : remainder, one spare bit wide
module seq_div_const #(
  parameter int WIDTH   = 11,
  parameter int DIVISOR = 5,
  localparam int REM_W  = $clog2(DIVISOR),
  localparam int CNT_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [REM_W:0]   remainder
);

  localparam logic [REM_W:0] DIV_C = (REM_W+1)'(DIVISOR);

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] quo;
  logic [REM_W:0]   rem;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [REM_W:0]   trial;
  logic             ge;

  // Partial remainder is always < DIVISOR, so its top bit is never needed
  // when shifting in the next dividend bit.
  assign trial = {rem[REM_W-1:0], dvd[WIDTH-1]};
  assign ge    = (trial >= DIV_C);
  assign done  = busy && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd  <= '0;
      quo  <= '0;
      rem  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      dvd  <= dividend;
      quo  <= '0;
      rem  <= '0;
      cnt  <= CNT_W'(WIDTH-1);
      busy <= 1'b1;
    end else if (busy) begin
      rem <= ge ? (trial - DIV_C) : trial;
      quo <= {quo[WIDTH-2:0], ge};
      dvd <= {dvd[WIDTH-2:0], 1'b0};
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/temp_sample_conditioner.sv
// temp_sample_conditioner
//   Block-averages 2^AVG_LOG2 raw temperature samples, converts the rounded
//   average to whole degC (clamped 0..MAX_C) and degF, and presents both as
//   stable 8-bit values that change together once per block.
//   Ports:
//     clk, rst     : clock, async active-low reset
//     smp          : sample valid/ready handshake (slave side)
//     temp_c       : whole degC, 0..MAX_C
//     temp_f       : whole degF, 32..210
//     temp_update  : one-cycle pulse when new temp_c/temp_f appear
//     temp_valid   : at least one result since reset
//     stale        : no result for STALE_CYCLES cycles
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_ACCUM  | ready; summing accepted samples until the block is full
//   ST_ROUND  | round/clamp the average, start the Fahrenheit divide
//   ST_DIV    | divider running (11 cycles)
//   ST_COMMIT | register temp_c/temp_f together, clear the block
module temp_sample_conditioner
  import temp_sample_conditioner_pkg::*;
#(
  parameter int AVG_LOG2     = 3,
  parameter int FRAC_BITS    = 4,
  parameter int MAX_C        = 99,
  parameter int STALE_CYCLES = 25000000
) (
  input  logic                      clk,
  input  logic                      rst,
  temp_sample_conditioner_if.slave  smp,
  output logic [OUT_W-1:0]          temp_c,
  output logic [OUT_W-1:0]          temp_f,
  output logic                      temp_update,
  output logic                      temp_valid,
  output logic                      stale
);

  localparam int ACC_W   = SAMPLE_W + AVG_LOG2;
  localparam int SH      = AVG_LOG2 + FRAC_BITS;
  localparam int AVG_W   = ACC_W + 1 - SH;
  localparam int STALE_W = $clog2(STALE_CYCLES + 1);
  localparam int DREM_W  = $clog2(DIV_CONST) + 1;

  localparam logic signed [ACC_W:0]   RND      = (ACC_W+1)'(1 << (SH-1));
  localparam logic signed [AVG_W-1:0] MAX_S    = AVG_W'(MAX_C);
  localparam logic [STALE_W-1:0]      STALE_TC = STALE_W'(STALE_CYCLES);

  logic [1:0]                state;
  logic signed [ACC_W-1:0]   acc;
  logic [AVG_LOG2-1:0]       samp_cnt;
  logic [STALE_W-1:0]        stale_cnt;
  logic [OUT_W-1:0]          c_reg;
  logic                      accept;
  logic signed [ACC_W:0]     rsum;
  logic signed [AVG_W-1:0]   avg;
  logic [OUT_W-1:0]          c_clamp;
  logic                      div_start;
  logic                      div_done;
  logic [DIV_BITS-1:0]       div_dividend;
  logic [DIV_BITS-1:0]       div_quo;
  logic [DREM_W-1:0]         div_rem;
  logic                      unused_div;

  assign smp.sample_ready = (state == ST_ACCUM);
  assign accept           = smp.sample_valid && (state == ST_ACCUM);

  // One guard bit so the rounding constant cannot overflow a full-scale sum.
  assign rsum = {acc[ACC_W-1], acc} + RND;
  assign avg  = rsum[ACC_W:SH];

  always_comb begin
    c_clamp = OUT_W'(avg);
    if (avg[AVG_W-1])      c_clamp = '0;
    else if (avg > MAX_S)  c_clamp = OUT_W'(MAX_C);
  end

  assign div_start    = (state == ST_ROUND);
  assign div_dividend = times9_plus2(c_clamp);

  seq_div_const #(
    .WIDTH   (DIV_BITS),
    .DIVISOR (DIV_CONST)
  ) u_div5 (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_dividend),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Remainder and quotient bits above 178 are never needed.
  assign unused_div = ^{div_rem, div_quo[DIV_BITS-1:OUT_W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_ACCUM;
      acc         <= '0;
      samp_cnt    <= '0;
      c_reg       <= '0;
      temp_c      <= '0;
      temp_f      <= OUT_W'(F_OFFSET);
      temp_update <= 1'b0;
      temp_valid  <= 1'b0;
    end else begin
      temp_update <= 1'b0;
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            acc      <= acc + {{AVG_LOG2{smp.sample_data[SAMPLE_W-1]}}, smp.sample_data};
            samp_cnt <= samp_cnt + 1'b1;
            if (&samp_cnt) state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          c_reg <= c_clamp;
          state <= ST_DIV;
        end
        ST_DIV: begin
          if (div_done) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          temp_c      <= c_reg;
          temp_f      <= div_quo[OUT_W-1:0] + OUT_W'(F_OFFSET);
          temp_update <= 1'b1;
          temp_valid  <= 1'b1;
          acc         <= '0;
          samp_cnt    <= '0;
          state       <= ST_ACCUM;
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     stale_cnt <= '0;
    else if (state == ST_COMMIT)  stale_cnt <= '0;
    else if (stale_cnt != STALE_TC) stale_cnt <= stale_cnt + 1'b1;
  end

  assign stale = (stale_cnt == STALE_TC);

endmodule

// File: tb/tb_temp_sample_conditioner.sv
module tb_temp_sample_conditioner;

  localparam int STALE   = 50;
  localparam int NSAMP   = 8;
  localparam int LATENCY = 13;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] temp_c;
  logic [7:0] temp_f;
  logic       temp_update;
  logic       temp_valid;
  logic       stale;

  int checks = 0;
  int errors = 0;

  temp_sample_conditioner_if sif ();

  temp_sample_conditioner #(
    .AVG_LOG2     (3),
    .FRAC_BITS    (4),
    .MAX_C        (99),
    .STALE_CYCLES (STALE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .smp         (sif.slave),
    .temp_c      (temp_c),
    .temp_f      (temp_f),
    .temp_update (temp_update),
    .temp_valid  (temp_valid),
    .stale       (stale)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: samples collected while the block is not busy, average
  // in real arithmetic, result shows up LATENCY cycles after the last sample.
  int m_cyc, m_since, m_cnt, m_pend, m_sum, m_commit_at;
  int m_pc, m_pf, m_c, m_f, m_upd, m_valid;

  always @(posedge clk or negedge rst) begin : model
    int  rdy;
    real a;
    int  c;
    if (!rst) begin
      m_cyc = 0; m_since = 0; m_cnt = 0; m_pend = 0; m_sum = 0; m_commit_at = 0;
      m_pc = 0; m_pf = 32; m_c = 0; m_f = 32; m_upd = 0; m_valid = 0;
    end else begin
      rdy = (m_pend == 0) ? 1 : 0;
      m_cyc++;
      m_upd = 0;
      if (m_pend != 0 && m_cyc == m_commit_at) begin
        m_c = m_pc; m_f = m_pf; m_upd = 1; m_valid = 1; m_pend = 0; m_since = 0;
      end else if (m_since < STALE) begin
        m_since++;
      end
      if (rdy != 0 && sif.sample_valid) begin
        m_sum += int'($signed(sif.sample_data));
        m_cnt++;
        if (m_cnt == NSAMP) begin
          a = (real'(m_sum) / real'(NSAMP)) / 16.0;
          c = $rtoi($floor(a + 0.5));
          if (c < 0)  c = 0;
          if (c > 99) c = 99;
          m_pc = c;
          m_pf = $rtoi($floor(real'(c) * 1.8 + 0.5)) + 32;
          m_pend = 1;
          m_commit_at = m_cyc + LATENCY;
          m_sum = 0;
          m_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("temp_c", int'(temp_c), m_c);
      chk("temp_f", int'(temp_f), m_f);
      chk("temp_update", int'(temp_update), m_upd);
      chk("temp_valid", int'(temp_valid), m_valid);
      chk("sample_ready", int'(sif.sample_ready), (m_pend == 0) ? 1 : 0);
      chk("stale", int'(stale), (m_since >= STALE) ? 1 : 0);
    end
  end

  task automatic send(input logic [11:0] d);
    int t;
    @(negedge clk);
    sif.sample_valid = 1'b1;
    sif.sample_data  = d;
    t = 0;
    while (!sif.sample_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic wait_update(input int exp_c, input int exp_f);
    int n;
    int got;
    @(negedge clk);
    sif.sample_valid = 1'b0;
    n = 0;
    got = 0;
    while (got == 0 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = int'(temp_update);
    end
    chk("update_latency", n, LATENCY);
    chk("blk_temp_c", int'(temp_c), exp_c);
    chk("blk_temp_f", int'(temp_f), exp_f);
    chk("blk_temp_valid", int'(temp_valid), 1);
    chk("blk_stale_clear", int'(stale), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_temp_c"}, int'(temp_c), 0);
    chk({tag, "_temp_f"}, int'(temp_f), 32);
    chk({tag, "_update"}, int'(temp_update), 0);
    chk({tag, "_valid"}, int'(temp_valid), 0);
    chk({tag, "_ready"}, int'(sif.sample_ready), 1);
    chk({tag, "_stale"}, int'(stale), 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int run;
    int n_upd;
    sif.sample_valid = 1'b0;
    sif.sample_data  = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_values("rst");
    @(negedge clk);
    rst = 1'b1;

    for (int j = 1; j <= 52; j++) begin
      @(negedge clk);
      if (j == 49) chk("stale_at_49", int'(stale), 0);
      if (j == 50) chk("stale_at_50", int'(stale), 1);
    end

    repeat (8) send(12'h190);
    wait_update(25, 77);

    repeat (4) send(12'h250);
    repeat (4) send(12'h258);
    wait_update(37, 99);

    repeat (8) send(12'hF60);
    wait_update(0, 32);

    repeat (8) send(12'h7F0);
    wait_update(99, 210);

    // Reset while the divider is running.
    repeat (8) send(12'h190);
    @(negedge clk);
    sif.sample_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_values("div_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_upd = 0;
    repeat (20) begin
      @(negedge clk);
      if (temp_update) n_upd++;
    end
    chk("no_update_after_reset", n_upd, 0);
    chk("post_reset_valid", int'(temp_valid), 0);

    // Continuous valid with incrementing data.
    run = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      sif.sample_valid = 1'b1;
      sif.sample_data  = 12'h100 + 12'(i);
      if (!sif.sample_ready) run++;
      else begin
        if (run > 0) chk("ready_low_run", run, LATENCY);
        run = 0;
      end
    end
    @(negedge clk);
    sif.sample_valid = 1'b0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
